// File: rtl/mac_pkg.sv
// Shared types for the radix-4 Booth MAC lane: FSM states, Booth digit
// control encodings and default operand/accumulator widths.
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit controls packed as {shift, neg, zero}
  typedef enum logic [2:0] {
    DIG_POS1 = 3'b000,
    DIG_ZERO = 3'b001,
    DIG_NEG1 = 3'b010,
    DIG_POS2 = 3'b100,
    DIG_NEG2 = 3'b110
  } booth_dig_t;

endpackage

// File: rtl/booth_digit_recoder.sv
// Radix-4 Booth recoder: multiplier triplet {b[2i+1], b[2i], b[2i-1]}
// to partial-product controls {shift, neg, zero}.
module booth_digit_recoder
  import mac_pkg::*;
(
  input  logic [2:0] triplet,
  output logic       shift,
  output logic       neg,
  output logic       zero
);

  booth_dig_t dig;

  always_comb begin
    dig = DIG_ZERO;
    case (triplet)
      3'b001, 3'b010: dig = DIG_POS1;
      3'b011:         dig = DIG_POS2;
      3'b100:         dig = DIG_NEG2;
      3'b101, 3'b110: dig = DIG_NEG1;
      default:        dig = DIG_ZERO;
    endcase
  end

  assign {shift, neg, zero} = dig;

endmodule

// File: rtl/booth_mac_sequencer.sv
// Sequential radix-4 Booth multiply-accumulate, one digit per cycle.
// Build option MAC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module booth_mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  input  logic                  acc_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  overflow,
  output logic                  pp_shift,
  output logic                  pp_neg,
  output logic                  pp_zero
);

  localparam int N  = DATA_WIDTH / 2;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam int PW = DATA_WIDTH + 2;
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [PW-1:0] ONE_P = PW'(1);
`ifdef MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic signed [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH:0]     b_reg;
  logic signed [SW-1:0]    psum_reg;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                    ovf_q;

  logic                    rec_shift, rec_neg, rec_zero, run, last;
  logic signed [PW-1:0]    a_ext, pp_mag, pp_dig;
  logic signed [SW-1:0]    pp_ext, pp_sh, sum;

  // Sum is one bit wider than the accumulator, so its MSB is the true sign
  function automatic logic signed [ACC_WIDTH-1:0] fit_acc(input logic signed [SW-1:0] s);
    if (SAT_EN && (s[SW-1] ^ s[SW-2]))
      fit_acc = s[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      fit_acc = s[ACC_WIDTH-1:0];
  endfunction

  booth_digit_recoder u_rec (
    .triplet (b_reg[2:0]),
    .shift   (rec_shift),
    .neg     (rec_neg),
    .zero    (rec_zero)
  );

  assign run    = (state_q == RUN);
  assign last   = (cnt_q == CW'(N - 1));
  assign a_ext  = {{2{a_reg[DATA_WIDTH-1]}}, a_reg};
  assign pp_mag = rec_shift ? (a_ext <<< 1) : a_ext;
  assign pp_dig = rec_zero ? '0 : (rec_neg ? (~pp_mag + ONE_P) : pp_mag);
  assign pp_ext = SW'(pp_dig);
  assign pp_sh  = pp_ext <<< {cnt_q, 1'b0};
  assign sum    = psum_reg + pp_sh;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        cnt_q <= '0;
        if (acc_clear) ovf_q <= 1'b0;
      end else if (run) begin
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          acc_q <= fit_acc(sum);
          if (sum[SW-1] ^ sum[SW-2]) ovf_q <= 1'b1;
        end
      end
    end
  end

  // Operand and partial-sum datapath registers carry no reset
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_reg    <= multiplicand;
      b_reg    <= {multiplier, 1'b0};
      psum_reg <= acc_clear ? '0 : SW'(acc_q);
    end else if (run) begin
      b_reg    <= b_reg >> 2;
      psum_reg <= sum;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;
  assign pp_shift = run & rec_shift;
  assign pp_neg   = run & rec_neg;
  assign pp_zero  = run & rec_zero;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Bench for booth_mac_sequencer: two lanes (24-bit and 16-bit accumulators)
// share one stimulus stream and are compared every cycle to an arithmetic model.
module tb_booth_mac_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, acc_clear;
  logic [7:0]  a_in, b_in;
  logic [1:0]  rdy, oval, ovf, psh, png, pzr;
  logic [23:0] acc8;
  logic [15:0] acc16;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  booth_mac_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(24)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .multiplicand(a_in), .multiplier(b_in), .acc_clear(acc_clear),
    .out_valid(oval[0]), .out_ready(out_ready), .acc_out(acc8), .overflow(ovf[0]),
    .pp_shift(psh[0]), .pp_neg(png[0]), .pp_zero(pzr[0])
  );

  booth_mac_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .multiplicand(a_in), .multiplier(b_in), .acc_clear(acc_clear),
    .out_valid(oval[1]), .out_ready(out_ready), .acc_out(acc16), .overflow(ovf[1]),
    .pp_shift(psh[1]), .pp_neg(png[1]), .pp_zero(pzr[1])
  );

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: mk = 0 idle, 1..N digit cycles, N+1 result waiting
  int         mk[2];
  longint     macc[2], mprev[2];
  bit         movf[2], mprev_ovf[2];
  logic [7:0] mb[2];
  int         aw[2] = '{24, 16};

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        mk[l] = 0; macc[l] = 0; mprev[l] = 0; movf[l] = 0; mprev_ovf[l] = 0;
      end else if (mk[l] == 0) begin
        if (in_valid) begin
          longint t, lim, mod;
          lim = longint'(1) <<< (aw[l] - 1);
          mod = longint'(1) <<< aw[l];
          mprev[l] = macc[l];
          if (acc_clear) movf[l] = 0;
          mprev_ovf[l] = movf[l];
          t = (acc_clear ? 0 : macc[l]) + longint'($signed(a_in)) * longint'($signed(b_in));
          if (t >= lim || t < -lim) begin
            movf[l] = 1;
`ifdef MAC_SAT_EN
            t = (t < 0) ? -lim : lim - 1;
`else
            t = t & (mod - 1);
            if (t >= lim) t = t - mod;
`endif
          end
          macc[l] = t;
          mb[l] = b_in;
          mk[l] = 1;
        end
      end else if (mk[l] <= N) begin
        mk[l] = mk[l] + 1;
      end else if (out_ready) begin
        mk[l] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      bit     running;
      longint act_acc;
      int     d, i;
      running = (mk[l] >= 1 && mk[l] <= N);
      act_acc = (l == 0) ? longint'($signed(acc8)) : longint'($signed(acc16));
      d = 0;
      if (running) begin
        i = mk[l] - 1;
        d = -2 * int'(mb[l][2*i+1]) + int'(mb[l][2*i]);
        if (i > 0) d = d + int'(mb[l][2*i-1]);
      end
      check($sformatf("in_ready[%0d]", l), rdy[l], (!rst && mk[l] == 0));
      check($sformatf("out_valid[%0d]", l), oval[l], (mk[l] == N + 1));
      check($sformatf("acc_out[%0d]", l), act_acc, running ? mprev[l] : macc[l]);
      check($sformatf("overflow[%0d]", l), ovf[l], running ? mprev_ovf[l] : movf[l]);
      check($sformatf("pp_shift[%0d]", l), psh[l], running && (d == 2 || d == -2));
      check($sformatf("pp_neg[%0d]", l), png[l], running && (d < 0));
      check($sformatf("pp_zero[%0d]", l), pzr[l], running && (d == 0));
    end
  end

  task automatic send(input int a, input int b, input bit clr);
    int w = 0;
    @(negedge clk);
    a_in = 8'(a); b_in = 8'(b); acc_clear = clr; in_valid = 1'b1;
    while (!rdy[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[0]) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; acc_clear = 1'b0;
  endtask

  task automatic get(input int hold, output longint r8, output longint r16,
                     output bit o8, output bit o16);
    int w = 0;
    @(negedge clk);
    while (!oval[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!oval[0]) check("get_timeout", 0, 1);
    r8 = longint'($signed(acc8)); r16 = longint'($signed(acc16));
    o8 = ovf[0]; o16 = ovf[1];
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0]; a_in = 8'($urandom); b_in = 8'($urandom); acc_clear = 1'b1;
      @(negedge clk);
      check("hold_acc", longint'($signed(acc8)), r8);
      check("hold_valid", oval[0], 1);
      check("hold_ready", rdy[0], 0);
    end
    in_valid = 1'b0; acc_clear = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    longint r8, r16;
    bit     o8, o16;
    int     lat;
    logic [2:0] pp_exp [4] = '{3'b001, 3'b010, 3'b010, 3'b100};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_clear = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", rdy[0], 0);
    check("rst_acc", acc8, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready", rdy[0], 1);

    // 7 * -3 with clear, latency counted including the accept edge
    send(7, -3, 1);
    lat = 1;
    while (!oval[0] && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, N + 1);
    get(0, r8, r16, o8, o16);
    check("t1_acc", r8, -21);
    check("t1_raw", acc8, 24'hFFFFEB);
    check("t1_ovf", o8, 0);

    send(127, 127, 0);
    get(0, r8, r16, o8, o16);
    check("t2_acc_a", r8, 16108);
    send(-128, -128, 0);
    get(0, r8, r16, o8, o16);
    check("t2_acc_b", r8, 32492);
    check("t2_acc16", r16, 32492);

    send(3, 4, 1);
    get(6, r8, r16, o8, o16);
    check("t3_acc", r8, 12);

    send(-128, -128, 1);
    get(0, r8, r16, o8, o16);
    check("t4_first", r16, 16384);
    send(-128, -128, 0);
    get(0, r8, r16, o8, o16);
    send(-128, -128, 0);
    get(0, r8, r16, o8, o16);
    check("t4_acc8", r8, 49152);
    check("t4_ovf8", o8, 0);
    check("t4_ovf16", o16, 1);
`ifdef MAC_SAT_EN
    check("t4_acc16", r16, 32767);
`else
    check("t4_acc16", r16, -16384);
`endif

    // Reset during the second digit cycle
    send(5, 9, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_ready", rdy[0], 1);
    check("t5_valid", oval[0], 0);
    check("t5_acc", acc8, 0);
    check("t5_ovf16", ovf[1], 0);
    send(5, 9, 0);
    get(0, r8, r16, o8, o16);
    check("t5_result", r8, 45);

    send(3, 8'b01101100, 1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check($sformatf("t6_digit%0d", i), {psh[0], png[0], pzr[0]}, pp_exp[i]);
    end
    get(0, r8, r16, o8, o16);
    check("t6_acc", r8, 324);

    for (int k = 0; k < 80; k++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if (k % 11 == 0) a = 128;
      if (k % 13 == 0) b = 128;
      send(a, b, ($urandom_range(0, 3) == 0));
      get(int'($urandom_range(0, 2)), r8, r16, o8, o16);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
